pipe_hazard_ctrl: RTL and testbench

PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

---
 rtl/pipe_hazard_ctrl.sv | 147 ++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: pipeline stall/flush/forwarding control with memory-wait, halt-drain and timeout tracking
module pipe_hazard_ctrl #(
  parameter int DRAIN_CYC  = 3,
  parameter int MEM_TO_LIM = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start_i,
  input  logic [3:0]  ra_i,
  input  logic [3:0]  rb_i,
  input  logic        ra_use_i,
  input  logic        rb_use_i,
  input  logic        ra_v_i,
  input  logic        rb_v_i,
  input  logic        halt_id_i,
  input  logic [3:0]  rg_ex_i,
  input  logic        we_c_ex_i,
  input  logic        we_v_ex_i,
  input  logic        mem_rd_ex_i,
  input  logic        br_taken_ex_i,
  input  logic [3:0]  rg_mem_i,
  input  logic        we_c_mem_i,
  input  logic        we_v_mem_i,
  input  logic        mem_busy_i,
  output logic        pc_we_o,
  output logic        we_if_id_o,
  output logic        we_id_ex_o,
  output logic        we_ex_mem_o,
  output logic        we_mem_wb_o,
  output logic        flush_if_id_o,
  output logic        flush_id_ex_o,
  output logic [1:0]  fwd_a_o,
  output logic [1:0]  fwd_b_o,
  output logic        busy_o,
  output logic        done_o,
  output logic        mem_to_o,
  output logic [15:0] stall_cnt_o
);
  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_RUN     = 2'd1;
  localparam logic [1:0] S_MEMWAIT = 2'd2;
  localparam logic [1:0] S_DRAIN   = 2'd3;
  localparam logic [15:0] DC     = 16'(DRAIN_CYC);
  localparam logic [15:0] TO_LIM = 16'(MEM_TO_LIM);
  logic [1:0]  state_q, state_d;
  logic        ret_q, ret_d;
  logic [15:0] drain_q, drain_d, to_q, to_d, stall_q, stall_d;
  logic        mem_to_q, mem_to_d, done_q, done_d;
  logic        a_ex, a_mem, b_ex, b_mem, load_use;
  logic [4:0]  en;
  logic        fl_if, fl_id;
  assign a_ex     = ra_use_i && ra_i == rg_ex_i  && (ra_v_i ? we_v_ex_i  : we_c_ex_i);
  assign a_mem    = ra_use_i && ra_i == rg_mem_i && (ra_v_i ? we_v_mem_i : we_c_mem_i);
  assign b_ex     = rb_use_i && rb_i == rg_ex_i  && (rb_v_i ? we_v_ex_i  : we_c_ex_i);
  assign b_mem    = rb_use_i && rb_i == rg_mem_i && (rb_v_i ? we_v_mem_i : we_c_mem_i);
  assign load_use = mem_rd_ex_i && (a_ex || b_ex);
  // Forwarding is purely combinational but held at register-file select during reset
  assign fwd_a_o = !rst_n ? 2'b00 : a_ex ? 2'b01 : a_mem ? 2'b10 : 2'b00;
  assign fwd_b_o = !rst_n ? 2'b00 : b_ex ? 2'b01 : b_mem ? 2'b10 : 2'b00;
  always_comb begin
    state_d  = state_q;
    ret_d    = ret_q;
    drain_d  = drain_q;
    done_d   = 1'b0;
    mem_to_d = mem_to_q;
    to_d     = 16'd0;
    en       = 5'b00000;
    fl_if    = 1'b0;
    fl_id    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          state_d  = S_RUN;
          mem_to_d = 1'b0;
        end
      end
      S_RUN: begin
        if (mem_busy_i) begin
          state_d = S_MEMWAIT;
          ret_d   = 1'b0;
        end else if (br_taken_ex_i) begin
          en    = 5'b11111;
          fl_if = 1'b1;
          fl_id = 1'b1;
        end else if (load_use) begin
          en    = 5'b00111;
          fl_id = 1'b1;
        end else if (halt_id_i) begin
          en      = 5'b00111;
          fl_id   = 1'b1;
          state_d = S_DRAIN;
          drain_d = DC;
        end else begin
          en = 5'b11111;
        end
      end
      S_MEMWAIT: begin
        to_d = (to_q == TO_LIM) ? to_q : to_q + 16'd1;
        if (to_d == TO_LIM) mem_to_d = 1'b1;
        if (!mem_busy_i) state_d = ret_q ? S_DRAIN : S_RUN;
      end
      default: begin
        if (mem_busy_i) begin
          state_d = S_MEMWAIT;
          ret_d   = 1'b1;
        end else begin
          en      = 5'b00111;
          fl_id   = 1'b1;
          drain_d = (drain_q == 16'd0) ? 16'd0 : drain_q - 16'd1;
          if (drain_q < 16'd2) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end
        end
      end
    endcase
    stall_d = (state_q == S_IDLE && start_i) ? 16'd0 :
              ((state_q == S_RUN || state_q == S_MEMWAIT) && !en[4] && stall_q != 16'hFFFF) ? stall_q + 16'd1 :
              stall_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      ret_q    <= 1'b0;
      drain_q  <= 16'd0;
      to_q     <= 16'd0;
      stall_q  <= 16'd0;
      mem_to_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      ret_q    <= ret_d;
      drain_q  <= drain_d;
      to_q     <= to_d;
      stall_q  <= stall_d;
      mem_to_q <= mem_to_d;
      done_q   <= done_d;
    end
  end
  assign {pc_we_o, we_if_id_o, we_id_ex_o, we_ex_mem_o, we_mem_wb_o} = en;
  assign flush_if_id_o = fl_if;
  assign flush_id_ex_o = fl_id;
  assign busy_o        = state_q != S_IDLE;
  assign done_o        = done_q;
  assign mem_to_o      = mem_to_q;
  assign stall_cnt_o   = stall_q;
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: directed scoreboard bench for pipe_hazard_ctrl
module tb_pipe_hazard_ctrl;
  logic clk = 1'b0;
  logic rst_n;
  logic start, ra_use, rb_use, ra_v, rb_v, halt, we_c_ex, we_v_ex, mem_rd, br, we_c_mem, we_v_mem, mem_busy;
  logic [3:0] ra, rb, rg_ex, rg_mem;
  logic pc_we, we_if_id, we_id_ex, we_ex_mem, we_mem_wb, fl_if, fl_id, busy, done, mem_to;
  logic [1:0] fwd_a, fwd_b;
  logic [15:0] stall_cnt;
  pipe_hazard_ctrl #(.DRAIN_CYC(3), .MEM_TO_LIM(255)) dut (
    .clk(clk), .rst_n(rst_n), .start_i(start), .ra_i(ra), .rb_i(rb),
    .ra_use_i(ra_use), .rb_use_i(rb_use), .ra_v_i(ra_v), .rb_v_i(rb_v), .halt_id_i(halt),
    .rg_ex_i(rg_ex), .we_c_ex_i(we_c_ex), .we_v_ex_i(we_v_ex), .mem_rd_ex_i(mem_rd),
    .br_taken_ex_i(br), .rg_mem_i(rg_mem), .we_c_mem_i(we_c_mem), .we_v_mem_i(we_v_mem),
    .mem_busy_i(mem_busy), .pc_we_o(pc_we), .we_if_id_o(we_if_id), .we_id_ex_o(we_id_ex),
    .we_ex_mem_o(we_ex_mem), .we_mem_wb_o(we_mem_wb), .flush_if_id_o(fl_if), .flush_id_ex_o(fl_id),
    .fwd_a_o(fwd_a), .fwd_b_o(fwd_b), .busy_o(busy), .done_o(done), .mem_to_o(mem_to),
    .stall_cnt_o(stall_cnt)
  );
  always #5 clk = ~clk;
  localparam int F_EN = 0, F_FL = 1, F_FA = 2, F_FB = 3, F_BUSY = 4, F_DONE = 5, F_TO = 6, F_ST = 7;
  typedef struct {
    string       tag;
    int          f;
    logic [15:0] v;
  } exp_t;
  exp_t q[$];
  int vecs = 0;
  int fails = 0;
  function automatic logic [15:0] get(int f);
    case (f)
      F_EN:    return {11'd0, pc_we, we_if_id, we_id_ex, we_ex_mem, we_mem_wb};
      F_FL:    return {14'd0, fl_if, fl_id};
      F_FA:    return {14'd0, fwd_a};
      F_FB:    return {14'd0, fwd_b};
      F_BUSY:  return {15'd0, busy};
      F_DONE:  return {15'd0, done};
      F_TO:    return {15'd0, mem_to};
      default: return stall_cnt;
    endcase
  endfunction
  task automatic push(string t, int f, logic [15:0] v);
    q.push_back('{t, f, v});
  endtask
  task automatic check();
    exp_t e;
    logic [15:0] o;
    #1;
    while (q.size() > 0) begin
      e = q.pop_front();
      o = get(e.f);
      vecs++;
      assert (o === e.v) else begin
        fails++;
        $error("FAIL %s: observed %h expected %h", e.tag, o, e.v);
      end
    end
  endtask
  task automatic tick(int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic clr();
    {start, ra_use, rb_use, ra_v, rb_v, halt, we_c_ex, we_v_ex, mem_rd, br, we_c_mem, we_v_mem, mem_busy} = '0;
    {ra, rb, rg_ex, rg_mem} = '0;
  endtask
  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
  initial begin
    clr();
    rst_n = 1'b0;
    ra = 4'd5; ra_use = 1'b1; rg_ex = 4'd5; we_c_ex = 1'b1;
    #1;
    push("rst_en", F_EN, 16'h0); push("rst_fl", F_FL, 16'h0); push("rst_fwda", F_FA, 16'h0);
    push("rst_busy", F_BUSY, 16'h0); push("rst_done", F_DONE, 16'h0);
    push("rst_to", F_TO, 16'h0); push("rst_stall", F_ST, 16'h0);
    check();
    @(negedge clk);
    rst_n = 1'b1;
    tick(2);
    push("idle_busy", F_BUSY, 16'h0); push("idle_en", F_EN, 16'h0); push("idle_fwd_ex", F_FA, 16'h1);
    check();
    rg_mem = 4'd5; we_c_mem = 1'b1;
    push("fwd_both", F_FA, 16'h1); check();
    we_c_ex = 1'b0;
    push("fwd_mem", F_FA, 16'h2); check();
    ra_v = 1'b1;
    push("fwd_vec_none", F_FA, 16'h0); check();
    rb = 4'd7; rb_use = 1'b1; rb_v = 1'b1; rg_mem = 4'd7; we_v_mem = 1'b1;
    push("fwdb_vec_mem", F_FB, 16'h2); check();
    clr();
    tick();
    pulse_start();
    push("run_busy", F_BUSY, 16'h1); push("run_stall0", F_ST, 16'h0);
    push("run_en", F_EN, 16'h1f); push("run_fl", F_FL, 16'h0);
    check();
    mem_rd = 1'b1; rg_ex = 4'd3; rb = 4'd3; rb_use = 1'b1; we_c_ex = 1'b1;
    push("lu_en", F_EN, 16'h07); push("lu_fl", F_FL, 16'h1); push("lu_fwdb", F_FB, 16'h1);
    check();
    tick();
    clr();
    push("lu_stall", F_ST, 16'h1); push("lu_after_en", F_EN, 16'h1f);
    check();
    br = 1'b1; halt = 1'b1;
    push("bh_en", F_EN, 16'h1f); push("bh_fl", F_FL, 16'h3);
    check();
    tick();
    clr();
    push("bh_run_en", F_EN, 16'h1f); push("bh_busy", F_BUSY, 16'h1); push("bh_done", F_DONE, 16'h0);
    check();
    pulse_start();
    push("start_ignored", F_ST, 16'h1); push("start_ign_busy", F_BUSY, 16'h1);
    check();
    halt = 1'b1;
    push("halt_en", F_EN, 16'h07); push("halt_fl", F_FL, 16'h1);
    check();
    tick();
    halt = 1'b0;
    for (int i = 0; i < 3; i++) begin
      push($sformatf("drain%0d_en", i), F_EN, 16'h07);
      push($sformatf("drain%0d_done", i), F_DONE, 16'h0);
      push($sformatf("drain%0d_busy", i), F_BUSY, 16'h1);
      check();
      tick();
    end
    push("halt_done", F_DONE, 16'h1); push("halt_idle", F_BUSY, 16'h0); push("halt_stall", F_ST, 16'h2);
    check();
    tick();
    push("done_once", F_DONE, 16'h0); push("idle_after", F_BUSY, 16'h0);
    check();
    pulse_start();
    push("start2_stall", F_ST, 16'h0);
    check();
    mem_busy = 1'b1;
    for (int c = 1; c <= 300; c++) begin
      push($sformatf("mw%0d_en", c), F_EN, 16'h0);
      push($sformatf("mw%0d_fl", c), F_FL, 16'h0);
      check();
      tick();
      if (c == 255) begin push("to_not_yet", F_TO, 16'h0); check(); end
      if (c == 256) begin push("to_set", F_TO, 16'h1); check(); end
    end
    push("mw_stall300", F_ST, 16'd300); push("mw_busy", F_BUSY, 16'h1);
    check();
    mem_busy = 1'b0;
    push("mw_exit_en", F_EN, 16'h0);
    check();
    tick();
    push("mw_resume_en", F_EN, 16'h1f); push("to_sticky", F_TO, 16'h1);
    check();
    halt = 1'b1;
    tick();
    halt = 1'b0;
    mem_busy = 1'b1;
    push("dmw_en", F_EN, 16'h0);
    check();
    tick();
    mem_busy = 1'b0;
    push("dmw_wait_en", F_EN, 16'h0); push("dmw_busy", F_BUSY, 16'h1);
    check();
    tick();
    for (int i = 0; i < 3; i++) begin
      push($sformatf("dres%0d_en", i), F_EN, 16'h07);
      push($sformatf("dres%0d_done", i), F_DONE, 16'h0);
      check();
      tick();
    end
    push("dres_done", F_DONE, 16'h1); push("dres_idle", F_BUSY, 16'h0);
    check();
    pulse_start();
    push("start_clr_to", F_TO, 16'h0); push("start_clr_st", F_ST, 16'h0);
    check();
    halt = 1'b1;
    tick();
    halt = 1'b0;
    push("rd_in_drain", F_BUSY, 16'h1); push("rd_stall", F_ST, 16'h1);
    check();
    rst_n = 1'b0;
    ra = 4'd2; ra_use = 1'b1; rg_ex = 4'd2; we_c_ex = 1'b1;
    #1;
    push("rd_en", F_EN, 16'h0); push("rd_fl", F_FL, 16'h0); push("rd_busy", F_BUSY, 16'h0);
    push("rd_done", F_DONE, 16'h0); push("rd_st", F_ST, 16'h0); push("rd_fwda", F_FA, 16'h0);
    check();
    @(negedge clk);
    rst_n = 1'b1;
    clr();
    tick();
    for (int i = 0; i < 4; i++) begin
      push($sformatf("rd_after%0d_done", i), F_DONE, 16'h0);
      push($sformatf("rd_after%0d_busy", i), F_BUSY, 16'h0);
      check();
      tick();
    end
    $display("== %0d vectors applied, %0d miscompares ==", vecs, fails);
    $finish;
  end
endmodule
